// File: rtl/dbg_guv_cmd_tx.sv
// dbg_guv_cmd_tx
// Command-stream transmitter at the head of the dbg_guv daisy chain.
// Serialises register-write requests into an (address, data) flit pair and
// commit requests (reg addr 4'hF) into a single address flit. The command bus
// has no backpressure, so this block alone sets flit order and spacing.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_TDATA       write value (ignored for commit)
//   req_core_addr   target governor address
//   req_reg_addr    target register, 4'hF = commit
//   req_TVALID/TREADY  request handshake; TREADY only in S_IDLE and not in rst
//   cmd_out_TDATA/TVALID  registered command flit to the chain
//   busy            registered, high whenever the FSM is not idle
//   cmds_sent       registered completed-command count, wraps
//
// state  | meaning
// S_IDLE | bus idle, waiting for a request
// S_ADDR | address flit on cmd_out
// S_DATA | data flit on cmd_out (writes only)
// S_GAP  | forced idle spacing after a command

module dbg_guv_cmd_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_SIZE   = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] req_TDATA,
    input  logic [ADDR_WIDTH-1:0] req_core_addr,
    input  logic [3:0]            req_reg_addr,
    input  logic                  req_TVALID,
    output logic                  req_TREADY,
    output logic [DATA_WIDTH-1:0] cmd_out_TDATA,
    output logic                  cmd_out_TVALID,
    output logic                  busy,
    output logic [CNT_SIZE-1:0]   cmds_sent
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_GAP} state_t;

    localparam logic [3:0] REG_COMMIT = 4'hF;
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES);
    localparam logic       HAS_GAP    = (GAP_CYCLES > 0);

    state_t                state_q, state_d;
    logic [3:0]            reg_q, reg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  busy_q, busy_d;
    logic [7:0]            gap_q, gap_d;
    logic [CNT_SIZE-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] addr_flit;
    logic                  hs;

    assign req_TREADY = (state_q == S_IDLE) && !rst;
    assign hs         = req_TVALID && req_TREADY;

    always_comb begin
        addr_flit = '0;
        addr_flit[ADDR_WIDTH+3:0] = {req_core_addr, req_reg_addr};
    end

    // Outputs are registered, so each is computed from the state being
    // entered; the address flit is built straight from the request inputs
    // at the handshake, which also latches core/reg addr for it.
    always_comb begin
        state_d  = state_q;
        reg_d    = reg_q;
        data_d   = data_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        tdata_d  = '0;
        tvalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    state_d  = S_ADDR;
                    reg_d    = req_reg_addr;
                    data_d   = req_TDATA;
                    tvalid_d = 1'b1;
                    tdata_d  = addr_flit;
                    if (req_reg_addr == REG_COMMIT) begin
                        cnt_d = cnt_q + CNT_SIZE'(1);
                    end
                end
            end
            S_ADDR: begin
                if (reg_q == REG_COMMIT) begin
                    state_d = HAS_GAP ? S_GAP : S_IDLE;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d  = S_DATA;
                    tvalid_d = 1'b1;
                    tdata_d  = data_q;
                    cnt_d    = cnt_q + CNT_SIZE'(1);
                end
            end
            S_DATA: begin
                state_d = HAS_GAP ? S_GAP : S_IDLE;
                gap_d   = GAP_LOAD;
            end
            S_GAP: begin
                if (gap_q <= 8'd1) begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            reg_q    <= '0;
            data_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            gap_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            busy_q   <= busy_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cmd_out_TDATA  = tdata_q;
    assign cmd_out_TVALID = tvalid_q;
    assign busy           = busy_q;
    assign cmds_sent      = cnt_q;

endmodule

// File: tb/tb_dbg_guv_cmd_tx.sv
module tb_dbg_guv_cmd_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dut0: default parameters
    logic        rst0;
    logic [31:0] a_tdata;
    logic [9:0]  a_core;
    logic [3:0]  a_reg;
    logic        a_valid;
    logic        a_ready, a_tvalid, a_busy;
    logic [31:0] a_out;
    logic [15:0] a_cnt;

    dbg_guv_cmd_tx dut0 (
        .clk(clk), .rst(rst0),
        .req_TDATA(a_tdata), .req_core_addr(a_core), .req_reg_addr(a_reg),
        .req_TVALID(a_valid), .req_TREADY(a_ready),
        .cmd_out_TDATA(a_out), .cmd_out_TVALID(a_tvalid),
        .busy(a_busy), .cmds_sent(a_cnt)
    );

    // dut1: GAP_CYCLES=2, dut2: CNT_SIZE=2
    logic        rst12;
    logic [31:0] b_tdata, c_tdata;
    logic [9:0]  b_core, c_core;
    logic [3:0]  b_reg, c_reg;
    logic        b_valid, c_valid;
    logic        b_ready, b_tvalid, b_busy, c_ready, c_tvalid, c_busy;
    logic [31:0] b_out, c_out;
    logic [15:0] b_cnt;
    logic [1:0]  c_cnt;

    dbg_guv_cmd_tx #(.GAP_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst12),
        .req_TDATA(b_tdata), .req_core_addr(b_core), .req_reg_addr(b_reg),
        .req_TVALID(b_valid), .req_TREADY(b_ready),
        .cmd_out_TDATA(b_out), .cmd_out_TVALID(b_tvalid),
        .busy(b_busy), .cmds_sent(b_cnt)
    );

    dbg_guv_cmd_tx #(.CNT_SIZE(2)) dut2 (
        .clk(clk), .rst(rst12),
        .req_TDATA(c_tdata), .req_core_addr(c_core), .req_reg_addr(c_reg),
        .req_TVALID(c_valid), .req_TREADY(c_ready),
        .cmd_out_TDATA(c_out), .cmd_out_TVALID(c_tvalid),
        .busy(c_busy), .cmds_sent(c_cnt)
    );

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_cnt [5];
        exp_cnt = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};

        rst0 = 1'b1; rst12 = 1'b1;
        a_valid = 1'b0; a_tdata = '0; a_core = '0; a_reg = '0;
        b_valid = 1'b0; b_tdata = '0; b_core = '0; b_reg = '0;
        c_valid = 1'b0; c_tdata = '0; c_core = '0; c_reg = '0;
        tick(); tick();
        chk("rst_ready",  32'(a_ready),  32'd0);
        chk("rst_tvalid", 32'(a_tvalid), 32'd0);
        chk("rst_tdata",  a_out,         32'd0);
        chk("rst_busy",   32'(a_busy),   32'd0);
        chk("rst_cnt",    32'(a_cnt),    32'd0);
        rst0 = 1'b0; rst12 = 1'b0;
        tick();
        chk("idle_ready", 32'(a_ready), 32'd1);

        // Write core 5, reg 2, data DEADBEEF
        a_core = 10'd5; a_reg = 4'd2; a_tdata = 32'hDEADBEEF; a_valid = 1'b1;
        tick();
        a_valid = 1'b0; a_tdata = 32'h11111111; a_core = 10'd9; a_reg = 4'd7;
        chk("wr_addr_v",   32'(a_tvalid), 32'd1);
        chk("wr_addr_d",   a_out,         32'h00000052);
        chk("wr_addr_rdy", 32'(a_ready),  32'd0);
        chk("wr_addr_bsy", 32'(a_busy),   32'd1);
        chk("wr_addr_cnt", 32'(a_cnt),    32'd0);
        tick();
        chk("wr_data_v",   32'(a_tvalid), 32'd1);
        chk("wr_data_d",   a_out,         32'hDEADBEEF);
        chk("wr_data_cnt", 32'(a_cnt),    32'd1);
        tick();
        chk("wr_end_v",    32'(a_tvalid), 32'd0);
        chk("wr_end_cnt",  32'(a_cnt),    32'd1);
        chk("wr_end_bsy",  32'(a_busy),   32'd0);

        // Commit core 3FF
        a_core = 10'h3FF; a_reg = 4'hF; a_tdata = 32'h12345678; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("cm_v",   32'(a_tvalid), 32'd1);
        chk("cm_d",   a_out,         32'h00003FFF);
        chk("cm_cnt", 32'(a_cnt),    32'd2);
        tick();
        chk("cm_end_v",   32'(a_tvalid), 32'd0);
        chk("cm_end_rdy", 32'(a_ready),  32'd1);

        // Four queued writes, valid held high, next request shown right after accept
        a_core = 10'd1; a_reg = 4'd0; a_tdata = 32'h1000; a_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("q_rdy_idle", 32'(a_ready), 32'd1);
            tick();
            if (k < 3) begin
                a_core = 10'(k + 2); a_reg = 4'(k + 1); a_tdata = 32'h1000 + 32'(k + 1);
            end else begin
                a_valid = 1'b0;
            end
            chk("q_addr_v", 32'(a_tvalid), 32'd1);
            chk("q_addr_d", a_out, (32'(k + 1) << 4) | 32'(k));
            chk("q_rdy_a",  32'(a_ready), 32'd0);
            tick();
            chk("q_data_v", 32'(a_tvalid), 32'd1);
            chk("q_data_d", a_out, 32'h1000 + 32'(k));
            chk("q_rdy_d",  32'(a_ready), 32'd0);
            tick();
            chk("q_gap_v",  32'(a_tvalid), 32'd0);
        end
        chk("q_cnt", 32'(a_cnt), 32'd6);

        // Reset during the address flit of a write
        a_core = 10'd7; a_reg = 4'd1; a_tdata = 32'hCAFEF00D; a_valid = 1'b1;
        tick();
        chk("rm_addr_d", a_out, 32'h00000071);
        rst0 = 1'b1;
        tick();
        chk("rm_v",    32'(a_tvalid), 32'd0);
        chk("rm_bsy",  32'(a_busy),   32'd0);
        chk("rm_cnt",  32'(a_cnt),    32'd0);
        chk("rm_rdy",  32'(a_ready),  32'd0);
        tick();
        rst0 = 1'b0; a_valid = 1'b0;
        tick();
        chk("rm_post_v",   32'(a_tvalid), 32'd0);
        chk("rm_post_bsy", 32'(a_busy),   32'd0);
        chk("rm_post_rdy", 32'(a_ready),  32'd1);
        tick();
        chk("rm_post2_v",  32'(a_tvalid), 32'd0);

        // GAP_CYCLES=2: write then commit
        b_core = 10'd1; b_reg = 4'd0; b_tdata = 32'hA5A5A5A5; b_valid = 1'b1;
        tick();
        b_core = 10'd2; b_reg = 4'hF; b_tdata = 32'h0;
        chk("g_addr_d", b_out, 32'h00000010);
        tick();
        chk("g_data_d", b_out, 32'hA5A5A5A5);
        chk("g_data_v", 32'(b_tvalid), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("g_gap_v",   32'(b_tvalid), 32'd0);
            chk("g_gap_bsy", 32'(b_busy),   32'd1);
            chk("g_gap_rdy", 32'(b_ready),  32'd0);
        end
        tick();
        chk("g_idle_v",   32'(b_tvalid), 32'd0);
        chk("g_idle_bsy", 32'(b_busy),   32'd0);
        chk("g_idle_rdy", 32'(b_ready),  32'd1);
        tick();
        b_valid = 1'b0;
        chk("g_cm_v",   32'(b_tvalid), 32'd1);
        chk("g_cm_d",   b_out,         32'h0000002F);
        chk("g_cm_cnt", 32'(b_cnt),    32'd2);
        tick();
        chk("g_cm_gap_bsy", 32'(b_busy), 32'd1);
        tick();
        chk("g_cm_gap2_bsy", 32'(b_busy), 32'd1);
        tick();
        chk("g_cm_end_bsy", 32'(b_busy), 32'd0);

        // CNT_SIZE=2: five commits wrap the counter
        c_core = 10'd3; c_reg = 4'hF; c_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("w_rdy", 32'(c_ready), 32'd1);
            tick();
            if (k == 4) c_valid = 1'b0;
            chk("w_v",   32'(c_tvalid), 32'd1);
            chk("w_cnt", 32'(c_cnt),    exp_cnt[k]);
            tick();
        end
        chk("w_end_v", 32'(c_tvalid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
